net_send_sink: RTL and testbench

NET_SEND_SINK -- requirements
Module: net_send_sink

---
 rtl/net_send_sink_if.sv | 22 ++
 rtl/net_send_sink.sv | 138 +++++++++++++
 tb/tb_net_send_sink.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/net_send_sink_if.sv
// AXI-Stream beat bundle feeding the network send sink.
// master drives tdata/tkeep/tvalid/tlast; slave drives tready.
interface net_send_sink_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata, tkeep, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/net_send_sink.sv
// Packet sink: patterned backpressure, framing/length checks, stats.
// Ports: clk, rst (async active-low), s_axis (AXIS slave), enable,
//   ready_pattern (per-cycle ready mask), clear_stats; outputs pkt_done
//   pulse, pkt/byte counters, last_pkt_bytes, len/frame error counters.
module net_send_sink #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int MAX_BEATS  = 32
) (
   input  logic           clk,
   input  logic           rst,
   net_send_sink_if.slave s_axis,
   input  logic           enable,
   input  logic [15:0]    ready_pattern,
   input  logic           clear_stats,
   output logic           pkt_done,
   output logic [31:0]    pkt_count,
   output logic [47:0]    byte_count,
   output logic [15:0]    last_pkt_bytes,
   output logic [15:0]    len_err_count,
   output logic [15:0]    frame_err_count
);
   localparam int BBW = $clog2(KEEP_WIDTH + 1);
   localparam int CW  = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] MAX_B = CW'(MAX_BEATS);

   typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

   state_t        state;
   logic [3:0]    idx;
   logic [CW-1:0] beats;
   logic [15:0]   pkt_len;
   logic [15:0]   hdr_len;
   logic          pkt_ferr;

   logic           hs;
   logic [BBW-1:0] beat_bytes;
   logic [CW-1:0]  beats_nxt;
   logic [16:0]    len_sum;
   logic [15:0]    len_nxt;
   logic [15:0]    hdr_cur;
   logic           keep_bad;
   logic           ferr_nxt;
   logic           lerr_nxt;
   logic           unused_tdata;

   // Reset gates tready directly so it drops the instant rst falls.
   assign s_axis.tready = rst & enable & ready_pattern[idx];
   assign hs            = s_axis.tvalid & s_axis.tready;
   assign unused_tdata  = ^s_axis.tdata;

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
         beat_bytes = beat_bytes + BBW'(s_axis.tkeep[i]);
   end

   // Per-packet accumulators restart from zero on a first beat.
   assign beats_nxt = (state == IDLE) ? CW'(1)
                                      : beats + CW'(1);
   assign len_sum = {1'b0, (state == IDLE) ? 16'd0 : pkt_len}
                  + 17'(beat_bytes);
   assign len_nxt = len_sum[16] ? 16'hFFFF : len_sum[15:0];

   // Header length: byte 16 is the MSB, byte 17 the LSB.
   assign hdr_cur = (state == IDLE)
                  ? {s_axis.tdata[135:128], s_axis.tdata[143:136]}
                  : hdr_len;

   // A last beat must hold 2^n-1 with n >= 1 (contiguous from bit 0).
   assign keep_bad = s_axis.tlast
      ? ((s_axis.tkeep == '0) ||
         ((s_axis.tkeep & (s_axis.tkeep + KEEP_WIDTH'(1))) != '0))
      : !(&s_axis.tkeep);

   assign ferr_nxt = ((state != IDLE) & pkt_ferr) | keep_bad
                   | (state == DRAIN);
   assign lerr_nxt = !ferr_nxt && ((len_nxt - 16'd14) != hdr_cur);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         idx             <= '0;
         beats           <= '0;
         pkt_len         <= '0;
         hdr_len         <= '0;
         pkt_ferr        <= 1'b0;
         pkt_done        <= 1'b0;
         pkt_count       <= '0;
         byte_count      <= '0;
         last_pkt_bytes  <= '0;
         len_err_count   <= '0;
         frame_err_count <= '0;
      end else begin
         idx      <= idx + 4'd1;
         pkt_done <= 1'b0;
         if (hs) begin
            beats      <= beats_nxt;
            pkt_len    <= len_nxt;
            pkt_ferr   <= ferr_nxt;
            byte_count <= byte_count + 48'(beat_bytes);
            unique case (state)
               IDLE: begin
                  hdr_len <= hdr_cur;
                  if (!s_axis.tlast) state <= BODY;
               end
               BODY: begin
                  if (s_axis.tlast)
                     state <= IDLE;
                  else if (beats_nxt == MAX_B)
                     state <= DRAIN;
               end
               DRAIN: begin
                  if (s_axis.tlast) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
            if (s_axis.tlast) begin
               pkt_done       <= 1'b1;
               pkt_count      <= pkt_count + 32'd1;
               last_pkt_bytes <= len_nxt;
               if (ferr_nxt && frame_err_count != 16'hFFFF)
                  frame_err_count <= frame_err_count + 16'd1;
               if (lerr_nxt && len_err_count != 16'hFFFF)
                  len_err_count <= len_err_count + 16'd1;
            end
         end
         // Clear overrides any same-cycle update; FSM keeps running.
         if (clear_stats) begin
            pkt_count       <= '0;
            byte_count      <= '0;
            last_pkt_bytes  <= '0;
            len_err_count   <= '0;
            frame_err_count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_net_send_sink.sv
// Randomized bench for net_send_sink against a packet-level model.
// Ports: drives s_axis/enable/pattern/clear, checks all outputs.
module tb_net_send_sink;
   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int MB = 32;
   localparam logic [KW-1:0] NONCONTIG = {(KW/16){16'h00FF}};

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] ready_pattern;
   logic        clear_stats;
   logic        pkt_done;
   logic [31:0] pkt_count;
   logic [47:0] byte_count;
   logic [15:0] last_pkt_bytes;
   logic [15:0] len_err_count;
   logic [15:0] frame_err_count;

   net_send_sink_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();

   net_send_sink #(
      .DATA_WIDTH(DW),
      .KEEP_WIDTH(KW),
      .MAX_BEATS (MB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axis         (s_axis),
      .enable         (enable),
      .ready_pattern  (ready_pattern),
      .clear_stats    (clear_stats),
      .pkt_done       (pkt_done),
      .pkt_count      (pkt_count),
      .byte_count     (byte_count),
      .last_pkt_bytes (last_pkt_bytes),
      .len_err_count  (len_err_count),
      .frame_err_count(frame_err_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit rand_en = 1'b0;

   logic [31:0] m_pkts;
   logic [47:0] m_bytes;
   logic [15:0] m_last;
   logic [15:0] m_lerr;
   logic [15:0] m_ferr;

   // Cycles since reset release: the position in the ready pattern.
   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_stats(input string tag);
      chk({tag, ".pkt_count"}, pkt_count, m_pkts);
      chk({tag, ".byte_count"}, byte_count, m_bytes);
      chk({tag, ".last_bytes"}, last_pkt_bytes, m_last);
      chk({tag, ".len_err"}, len_err_count, m_lerr);
      chk({tag, ".frame_err"}, frame_err_count, m_ferr);
   endtask

   task automatic model_zero();
      m_pkts  = '0;
      m_bytes = '0;
      m_last  = '0;
      m_lerr  = '0;
      m_ferr  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      s_axis.tvalid = 1'b0;
      model_zero();
      #1;
      chk("rst.tready", s_axis.tready, 1'b0);
      chk("rst.pkt_done", pkt_done, 1'b0);
      check_stats("rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Present one beat from a negedge; return at the negedge after
   // the handshake.
   task automatic send_beat(input logic [DW-1:0] d,
                            input logic [KW-1:0] k,
                            input logic l,
                            input bit cd);
      int w;
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = l;
      s_axis.tvalid = 1'b1;
      w = 0;
      forever begin
         if (rand_en) enable = ($urandom_range(0, 3) != 0);
         #1;
         chk("tready", s_axis.tready,
             enable & ready_pattern[cyc[3:0]]);
         if (s_axis.tready) break;
         w++;
         if (w > 400) begin
            chk("handshake_timeout", 1'b0, 1'b1);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      if (cd) chk("pkt_done", pkt_done, l);
   endtask

   // kind: 0 clean, 1 hole in first beat's keep, 2 non-contiguous
   // last keep, 3 zero last keep.
   task automatic send_pkt(input int nb, input int lastn,
                           input int kind, input bit hdr_ok,
                           input logic [15:0] hdr_in,
                           input bit clr);
      logic [KW-1:0] kq[$];
      logic [KW-1:0] k;
      logic [KW-1:0] lowmask;
      logic [DW-1:0] d;
      logic [15:0]   hdr;
      logic [15:0]   len16;
      int len;
      int pc;
      bit fe;
      bit le;
      for (int b = 0; b < nb; b++) begin
         k = '1;
         if (b == nb - 1) begin
            k = k >> (KW - lastn);
            if (kind == 2) k = NONCONTIG;
            if (kind == 3) k = '0;
         end else if (kind == 1 && b == 0) begin
            k[5] = 1'b0;
         end
         kq.push_back(k);
      end
      len = 0;
      fe  = (nb > MB);
      for (int i = 0; i < nb; i++) begin
         pc  = $countones(kq[i]);
         len = len + pc;
         if (i < nb - 1 && pc != KW) fe = 1'b1;
         if (i == nb - 1) begin
            lowmask = '1;
            lowmask = (pc == 0) ? '0 : lowmask >> (KW - pc);
            if (pc == 0 || kq[i] != lowmask) fe = 1'b1;
         end
      end
      len16 = (len > 65535) ? 16'hFFFF : 16'(len);
      hdr   = hdr_ok ? 16'(len16 - 16'd14) : hdr_in;
      le    = !fe && (16'(len16 - 16'd14) != hdr);
      for (int b = 0; b < nb; b++) begin
         for (int w = 0; w < DW / 32; w++)
            d[w*32 +: 32] = $urandom;
         if (b == 0) begin
            d[128 +: 8] = hdr[15:8];
            d[136 +: 8] = hdr[7:0];
         end
         if (clr && b == nb - 1) clear_stats = 1'b1;
         send_beat(d, kq[b], b == nb - 1, !clr);
         clear_stats = 1'b0;
      end
      if (clr) begin
         model_zero();
      end else begin
         m_pkts  = m_pkts + 32'd1;
         m_bytes = m_bytes + 48'(len);
         m_last  = len16;
         if (fe && m_ferr != 16'hFFFF) m_ferr = m_ferr + 16'd1;
         if (le && m_lerr != 16'hFFFF) m_lerr = m_lerr + 16'd1;
      end
   endtask

   task automatic run_random(input int npkts);
      int nb;
      int kind;
      for (int p = 0; p < npkts; p++) begin
         if (p % 20 == 0)
            ready_pattern = 16'($urandom) | 16'h0001;
         nb = ($urandom_range(0, 15) == 0)
            ? $urandom_range(30, 36) : $urandom_range(1, 6);
         kind = $urandom_range(0, 9);
         kind = (kind < 6) ? 0 : kind - 6;
         if (kind == 1 && nb == 1) kind = 0;
         send_pkt(nb, $urandom_range(1, KW), kind,
                  $urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 29) == 0);
         check_stats("rand");
      end
   endtask

   initial begin
      rst           = 1'b0;
      enable        = 1'b1;
      ready_pattern = 16'hFFFF;
      clear_stats   = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tkeep  = '0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      model_zero();
      #3;
      chk("init.tready", s_axis.tready, 1'b0);
      chk("init.pkt_done", pkt_done, 1'b0);
      check_stats("init");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      send_pkt(4, KW, 0, 1'b0, 16'h00F2, 1'b0);
      check_stats("basic");
      chk("basic.bytes256", byte_count, 48'd256);
      chk("basic.last256", last_pkt_bytes, 16'd256);

      do_reset();
      send_pkt(4, KW, 0, 1'b0, 16'h00F0, 1'b0);
      check_stats("hdr_bad");
      chk("hdr_bad.len_err1", len_err_count, 16'd1);

      do_reset();
      ready_pattern = 16'h5555;
      for (int p = 0; p < 64; p++)
         send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("alt");
      chk("alt.pkts64", pkt_count, 32'd64);
      chk("alt.bytes16384", byte_count, 48'd16384);

      do_reset();
      ready_pattern = 16'hFFFF;
      send_pkt(40, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("oversize");
      chk("oversize.last2560", last_pkt_bytes, 16'd2560);
      send_pkt(32, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("max_beats");
      send_pkt(33, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("max_plus1");

      do_reset();
      send_pkt(4, KW, 2, 1'b1, 16'h0000, 1'b0);
      check_stats("noncontig");
      send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("after_noncontig");
      send_pkt(3, KW, 3, 1'b1, 16'h0000, 1'b0);
      check_stats("zero_keep");
      send_pkt(3, 10, 1, 1'b1, 16'h0000, 1'b0);
      check_stats("mid_hole");
      send_pkt(1, 20, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("one_beat");

      do_reset();
      send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b0);
      send_beat({DW{1'b1}}, '1, 1'b0, 1'b1);
      send_beat({DW{1'b1}}, '1, 1'b0, 1'b1);
      do_reset();
      send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("post_reset");
      chk("post_reset.pkts1", pkt_count, 32'd1);
      chk("post_reset.bytes256", byte_count, 48'd256);
      send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b1);
      check_stats("clear");
      send_pkt(4, KW, 0, 1'b1, 16'h0000, 1'b0);
      check_stats("after_clear");

      do_reset();
      rand_en = 1'b1;
      run_random(200);
      rand_en = 1'b0;
      enable  = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end
endmodule
